// File: rtl/display_scan_controller.sv
// display_scan_controller: time-multiplexes one BCD encoder across NUM_DIGITS digits with guard gaps
// and a frame-synchronous, double-buffered display update.
module display_scan_controller #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 50000,
   parameter int GAP_CYCLES  = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] digits_in,
   input  logic [NUM_DIGITS-1:0]   blank_in,
   output logic [3:0]              bcd,
   output logic [NUM_DIGITS-1:0]   digit_en,
   output logic                    load_ack,
   output logic                    frame_done
);
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int CMAX = REFRESH_DIV > GAP_CYCLES ? REFRESH_DIV : GAP_CYCLES;
   localparam int CW   = $clog2(CMAX + 1);
   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;
   state_t                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [4*NUM_DIGITS-1:0] act_dig_q, act_dig_d, pend_dig_q, pend_dig_d;
   logic [NUM_DIGITS-1:0]   act_blk_q, act_blk_d, pend_blk_q, pend_blk_d;
   logic                    pend_q, pend_d;
   logic [3:0]              bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0]   en_q, en_d;
   logic                    ack_q, ack_d, fd_q, fd_d;
   logic                    commit;
   logic [3:0]              dig;
   always_comb begin
      commit  = state_q == IDLE ||
                (state_q == GAP && cnt_q == CW'(GAP_CYCLES - 1) && idx_q == IW'(NUM_DIGITS - 1));
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q + 1'b1;
      if (state_q == IDLE) begin
         state_d = SHOW;
         idx_d   = '0;
         cnt_d   = '0;
      end else if (state_q == SHOW && cnt_q == CW'(REFRESH_DIV - 1)) begin
         state_d = GAP;
         cnt_d   = '0;
      end else if (state_q == GAP && cnt_q == CW'(GAP_CYCLES - 1)) begin
         state_d = SHOW;
         cnt_d   = '0;
         idx_d   = idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
      end
      // A load coinciding with a commit becomes the next pending frame.
      act_dig_d  = commit && pend_q ? pend_dig_q : act_dig_q;
      act_blk_d  = commit && pend_q ? pend_blk_q : act_blk_q;
      pend_d     = load | (pend_q & ~commit);
      pend_dig_d = load ? digits_in : pend_dig_q;
      pend_blk_d = load ? blank_in : pend_blk_q;
      dig        = act_dig_d[{idx_d, 2'b00} +: 4];
      bcd_d      = state_d == SHOW ? dig : bcd_q;
      en_d       = state_d == SHOW && !act_blk_d[idx_d] && dig <= 4'd9 ? NUM_DIGITS'(1) << idx_d : '0;
      ack_d      = commit & pend_q;
      fd_d       = commit;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         cnt_q      <= '0;
         act_dig_q  <= '0;
         act_blk_q  <= '1;
         pend_dig_q <= '0;
         pend_blk_q <= '0;
         pend_q     <= 1'b0;
         bcd_q      <= '0;
         en_q       <= '0;
         ack_q      <= 1'b0;
         fd_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         act_dig_q  <= act_dig_d;
         act_blk_q  <= act_blk_d;
         pend_dig_q <= pend_dig_d;
         pend_blk_q <= pend_blk_d;
         pend_q     <= pend_d;
         bcd_q      <= bcd_d;
         en_q       <= en_d;
         ack_q      <= ack_d;
         fd_q       <= fd_d;
      end
   end
   assign bcd        = bcd_q;
   assign digit_en   = en_q;
   assign load_ack   = ack_q;
   assign frame_done = fd_q;
endmodule

// File: tb/tb_display_scan_controller.sv
// tb_display_scan_controller: directed frames with a per-cycle expected-output queue
module tb_display_scan_controller;
  localparam int ND = 4;
  localparam int RD = 4;
  localparam int GC = 1;
  logic clk = 1'b0;
  logic rst;
  logic load;
  logic [15:0] digits_in;
  logic [3:0] blank_in;
  logic [3:0] bcd;
  logic [3:0] digit_en;
  logic load_ack;
  logic frame_done;
  int total = 0;
  int bad = 0;
  logic [9:0] sb[$];
  logic [9:0] exp_v;
  always #5 clk = ~clk;
  display_scan_controller #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GAP_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .load(load), .digits_in(digits_in), .blank_in(blank_in),
    .bcd(bcd), .digit_en(digit_en), .load_ack(load_ack), .frame_done(frame_done)
  );
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_v = sb.pop_front();
      total++;
      assert ({bcd, digit_en, load_ack, frame_done} === exp_v) else begin
        bad++;
        $error("FAIL scan t=%0t obs bcd=%h en=%b ack=%b fd=%b exp bcd=%h en=%b ack=%b fd=%b", $time,
               bcd, digit_en, load_ack, frame_done, exp_v[9:6], exp_v[5:2], exp_v[1], exp_v[0]);
      end
    end
  end
  initial begin
    #100000;
    bad++;
    $error("FAIL timeout: test did not finish in time");
    $finish;
  end
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic push_frame(input logic [15:0] d, input logic [3:0] b, input logic ack, input int n);
    int s, c;
    logic [3:0] dv, en;
    for (int k = 0; k < n; k++) begin
      s = k / (RD + GC);
      c = k % (RD + GC);
      dv = d[4*s +: 4];
      en = (c < RD && !b[s] && dv <= 4'd9) ? 4'(1 << s) : 4'b0;
      sb.push_back({dv, en, ack && k == 0, k == 0});
    end
  endtask
  task automatic do_frame(input logic [15:0] d, input logic [3:0] b, input logic ack,
                          input int at_a, input logic [15:0] da, input logic [3:0] ba,
                          input int at_b, input logic [15:0] db, input logic [3:0] bb);
    push_frame(d, b, ack, 20);
    for (int j = 1; j <= 20; j++) begin
      step();
      load = j == at_a || j == at_b;
      digits_in = j == at_b ? db : da;
      blank_in = j == at_b ? bb : ba;
    end
  endtask
  initial begin
    rst = 1'b1;
    load = 1'b0;
    digits_in = '0;
    blank_in = '0;
    step();
    sb.push_back(10'h0);
    sb.push_back(10'h0);
    step();
    step();
    total++;
    if ({bcd, digit_en, load_ack, frame_done} !== 10'h0) begin
      bad++;
      $error("FAIL reset state t=%0t bcd=%h en=%b ack=%b fd=%b", $time, bcd, digit_en, load_ack, frame_done);
    end
    rst = 1'b0;
    do_frame(16'h0000, 4'hF, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    do_frame(16'h0000, 4'hF, 1'b0, 5, 16'h4321, 4'h0, 0, 16'h0, 4'h0);
    do_frame(16'h4321, 4'h0, 1'b1, 10, 16'h3A21, 4'b0001, 0, 16'h0, 4'h0);
    do_frame(16'h3A21, 4'b0001, 1'b1, 3, 16'h1111, 4'h0, 8, 16'h2222, 4'h0);
    do_frame(16'h2222, 4'h0, 1'b1, 4, 16'h5555, 4'h0, 20, 16'h6666, 4'h0);
    do_frame(16'h5555, 4'h0, 1'b1, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    do_frame(16'h6666, 4'h0, 1'b1, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    push_frame(16'h6666, 4'h0, 1'b0, 11);
    for (int j = 1; j <= 11; j++) begin
      step();
      load = j == 3;
      digits_in = 16'h7777;
      blank_in = 4'h0;
    end
    rst = 1'b1;
    sb.push_back(10'h0);
    step();
    rst = 1'b0;
    do_frame(16'h0000, 4'hF, 1'b0, 0, 16'h0, 4'h0, 0, 16'h0, 4'h0);
    step();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $error("FAIL scoreboard not drained: %0d entries left", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
